alu_control_unit_param: RTL

- Parametrised one-hot control FSM for the add/sub/Radix-4 Booth multiply/SRT-2 divide datapath.
- Generalises the fixed 8-bit controller to any even WIDTH. The iteration, SRT-2 and leading-zero counters move inside the block.
- New behaviour: output handshake stall, divide-by-zero abort, busy flag, and recovery from illegal one-hot states.
- Sits between the top-level bus interface and the A/Q/Q'/M register and adder datapath.

---
 rtl/alu_cu_pkg.sv | 46 ++++
 rtl/alu_cu_counters.sv | 66 ++++++
 rtl/alu_control_unit_param.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_cu_pkg.sv
// Shared constants for the one-hot ALU control unit: op-codes, state indices
// and small helpers for building and validating one-hot state vectors.
package alu_cu_pkg;

  localparam int NUM_STATES = 18;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int S_IDLE      = 0;
  localparam int S_LOADA     = 1;
  localparam int S_LOADQ     = 2;
  localparam int S_LOADM     = 3;
  localparam int S_ADDM      = 4;
  localparam int S_ADDM_CORR = 5;
  localparam int S_ADD1QP    = 6;
  localparam int S_QSUBQP    = 7;
  localparam int S_PUSHA     = 8;
  localparam int S_PUSHQ     = 9;
  localparam int S_RSH1      = 10;
  localparam int S_RSH2      = 11;
  localparam int S_CNTR      = 12;
  localparam int S_LSHIFT    = 13;
  localparam int S_CNTL      = 14;
  localparam int S_LSH0      = 15;
  localparam int S_RSH0      = 16;
  localparam int S_ERR       = 17;

  typedef logic [NUM_STATES-1:0] state_vec_t;

  // One-hot vector with only bit idx set.
  function automatic state_vec_t st(input int idx);
    state_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input state_vec_t v);
    return (v != '0) && ((v & (v - state_vec_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/alu_cu_counters.sv
// Iteration counters for the control unit: Radix-4 multiply count, SRT-2
// iteration count and the leading-zero count used to undo normalisation.
module alu_cu_counters
  import alu_cu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic clk,
  input  logic reset_input,
  input  logic clr_i,
  input  logic r4_inc_i,
  input  logic srt_inc_i,
  input  logic lz_inc_i,
  input  logic lz_dec_i,
  output logic r4_last_o,
  output logic srt_last_o,
  output logic lz_zero_o
);

  localparam logic [CNT_W-1:0] R4_LAST  = CNT_W'(WIDTH / 2 - 1);
  localparam logic [CNT_W-1:0] SRT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LZ_MAX   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] r4_q, r4_d;
  logic [CNT_W-1:0] srt_q, srt_d;
  logic [CNT_W-1:0] lz_q, lz_d;

  // Next-count logic; clear wins, lz saturates at both ends.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    r4_d  = r4_q;
    srt_d = srt_q;
    lz_d  = lz_q;
    if (clr_i) begin
      r4_d  = '0;
      srt_d = '0;
      lz_d  = '0;
    end else begin
      if (r4_inc_i)                        r4_d  = r4_q + ONE;
      if (srt_inc_i)                       srt_d = srt_q + ONE;
      if (lz_inc_i && (lz_q != LZ_MAX))    lz_d  = lz_q + ONE;
      else if (lz_dec_i && (lz_q != '0))   lz_d  = lz_q - ONE;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset_input) begin
      r4_q  <= '0;
      srt_q <= '0;
      lz_q  <= '0;
    end else begin
      r4_q  <= r4_d;
      srt_q <= srt_d;
      lz_q  <= lz_d;
    end
  end

  assign r4_last_o  = (r4_q == R4_LAST);
  assign srt_last_o = (srt_q == SRT_LAST);
  assign lz_zero_o  = (lz_q == '0);

endmodule

// File: rtl/alu_control_unit_param.sv
// One-hot control FSM for the add/sub, Radix-4 Booth multiply and SRT-2
// divide datapath. Datapath strobes are decoded from the next state, so a
// strobe is high in the cycle whose closing edge enters the named state.
module alu_control_unit_param
  import alu_cu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_input,
  input  logic                  BEGIN,
  input  logic [1:0]            op_code,
  input  logic [2:0]            bits_of_Q,
  input  logic [2:0]            bits_of_A,
  input  logic                  sgn_bit_of_M,
  input  logic                  m_is_zero,
  input  logic                  out_ready,
  output logic                  load_A_inbus,
  output logic                  load_Q_inbus,
  output logic                  load_M_inbus,
  output logic                  init_A0,
  output logic                  init_counters,
  output logic                  load_A_adder,
  output logic                  load_Qp_adder,
  output logic                  load_Q_adder,
  output logic                  rshift,
  output logic                  lshift,
  output logic                  sel_sub,
  output logic                  sel_AM,
  output logic                  sel_2M,
  output logic                  sel_Qp_corr,
  output logic                  sel_Q_minus_Qp,
  output logic                  write_Qs,
  output logic                  Q_value,
  output logic                  Qprim_value,
  output logic                  push_A,
  output logic                  push_Q,
  output logic                  END,
  output logic                  busy,
  output logic                  div_by_zero,
  output logic [NUM_STATES-1:0] state_dbg
);

  state_vec_t state_q, state_d;
  state_vec_t cmd;
  state_vec_t div_iter_next;
  logic [1:0] op_q, op_d;
  logic       srt_flag_q, srt_flag_d;
  logic       state_legal;
  logic       q_nop;
  logic       a_active;
  logic       r4_last, srt_last, lz_zero;

  assign state_legal = is_onehot(state_q);
  assign q_nop       = (bits_of_Q == 3'b000) || (bits_of_Q == 3'b111);
  assign a_active    = (bits_of_A != 3'b000) && (bits_of_A != 3'b111);

  alu_cu_counters #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counters (
    .clk         (clk),
    .reset_input (reset_input),
    .clr_i       (init_counters),
    .r4_inc_i    (cmd[S_CNTR]),
    .srt_inc_i   (cmd[S_CNTL]),
    .lz_inc_i    (cmd[S_LSH0]),
    .lz_dec_i    (cmd[S_RSH0]),
    .r4_last_o   (r4_last),
    .srt_last_o  (srt_last),
    .lz_zero_o   (lz_zero)
  );

  // State, latched op-code and SRT flag registers.
  always_ff @(posedge clk) begin
    if (reset_input) begin
      state_q    <= st(S_IDLE);
      op_q       <= OP_ADD;
      srt_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      srt_flag_q <= srt_flag_d;
    end
  end

  // Next-state logic; any illegal vector falls back to IDLE.
  always_comb begin
    state_d    = st(S_IDLE);
    op_d       = op_q;
    srt_flag_d = srt_flag_q;
    // After the last SRT step, correct a negative remainder first.
    if (srt_last) div_iter_next = bits_of_A[2] ? st(S_ADDM_CORR) : st(S_QSUBQP);
    else          div_iter_next = st(S_CNTL);

    if (state_legal) begin
      case (1'b1)
        state_q[S_IDLE]: begin
          if (BEGIN) begin
            op_d    = op_code;
            state_d = (op_code == OP_MUL) ? st(S_LOADQ) : st(S_LOADA);
          end
        end
        state_q[S_LOADA]:     state_d = (op_q == OP_DIV) ? st(S_LOADQ) : st(S_LOADM);
        state_q[S_LOADQ]:     state_d = st(S_LOADM);
        state_q[S_LOADM]: begin
          case (op_q)
            OP_MUL:  state_d = q_nop ? st(S_RSH1) : st(S_ADDM);
            OP_DIV: begin
              if (m_is_zero)         state_d = st(S_ERR);
              else if (sgn_bit_of_M) state_d = st(S_LSHIFT);
              else                   state_d = st(S_LSH0);
            end
            default: state_d = st(S_ADDM);
          endcase
        end
        state_q[S_ADDM]: begin
          case (op_q)
            OP_MUL:  state_d = st(S_RSH1);
            OP_DIV:  state_d = div_iter_next;
            default: state_d = st(S_PUSHA);
          endcase
        end
        state_q[S_ADDM_CORR]: state_d = st(S_ADD1QP);
        state_q[S_ADD1QP]:    state_d = st(S_QSUBQP);
        state_q[S_QSUBQP]:    state_d = lz_zero ? st(S_PUSHQ) : st(S_RSH0);
        state_q[S_RSH0]:      state_d = lz_zero ? st(S_PUSHQ) : st(S_RSH0);
        state_q[S_PUSHA]: begin
          if (!out_ready)          state_d = st(S_PUSHA);
          else if (op_q == OP_MUL) state_d = st(S_PUSHQ);
          else                     state_d = st(S_IDLE);
        end
        state_q[S_PUSHQ]: begin
          if (!out_ready)          state_d = st(S_PUSHQ);
          else if (op_q == OP_DIV) state_d = st(S_PUSHA);
          else                     state_d = st(S_IDLE);
        end
        state_q[S_RSH1]:      state_d = st(S_RSH2);
        state_q[S_RSH2]:      state_d = r4_last ? st(S_PUSHA) : st(S_CNTR);
        state_q[S_CNTR]:      state_d = q_nop ? st(S_RSH1) : st(S_ADDM);
        state_q[S_LSHIFT]:    state_d = srt_flag_q ? st(S_ADDM) : div_iter_next;
        state_q[S_CNTL]:      state_d = st(S_LSHIFT);
        state_q[S_LSH0]:      state_d = sgn_bit_of_M ? st(S_LSHIFT) : st(S_LSH0);
        state_q[S_ERR]:       state_d = st(S_IDLE);
        default:              state_d = st(S_IDLE);
      endcase
    end

    if (state_d[S_LSHIFT]) srt_flag_d = a_active;
  end

  // Strobe decode from the next state; everything is forced low during reset.
  always_comb begin
    cmd            = reset_input ? '0 : state_d;
    load_A_inbus   = cmd[S_LOADA];
    load_Q_inbus   = cmd[S_LOADQ];
    load_M_inbus   = cmd[S_LOADM];
    init_A0        = cmd[S_LOADQ] & state_q[S_IDLE];
    init_counters  = (cmd[S_LOADA] | cmd[S_LOADQ]) & state_q[S_IDLE];
    load_A_adder   = cmd[S_ADDM] | cmd[S_ADDM_CORR];
    load_Qp_adder  = cmd[S_ADD1QP];
    load_Q_adder   = cmd[S_QSUBQP];
    rshift         = cmd[S_RSH1] | cmd[S_RSH2] | cmd[S_RSH0];
    lshift         = cmd[S_LSHIFT] | cmd[S_LSH0];
    sel_AM         = cmd[S_ADDM] | cmd[S_ADDM_CORR];
    sel_2M         = cmd[S_ADDM] & (op_q == OP_MUL) &
                     ((bits_of_Q == 3'b011) || (bits_of_Q == 3'b100));
    sel_Qp_corr    = cmd[S_ADD1QP];
    sel_Q_minus_Qp = cmd[S_QSUBQP];
    write_Qs       = cmd[S_LSHIFT];
    Q_value        = cmd[S_LSHIFT] & srt_flag_d & ~bits_of_A[2];
    Qprim_value    = cmd[S_LSHIFT] & srt_flag_d &  bits_of_A[2];
    push_A         = cmd[S_PUSHA];
    push_Q         = cmd[S_PUSHQ];

    sel_sub = cmd[S_QSUBQP];
    if (cmd[S_ADDM]) begin
      case (op_q)
        OP_MUL:  sel_sub = bits_of_Q[2];
        OP_DIV:  sel_sub = ~bits_of_A[2];
        default: sel_sub = op_q[0];
      endcase
    end

    END         = ~reset_input & state_legal & ~state_q[S_IDLE] & state_d[S_IDLE];
    div_by_zero = ~reset_input & state_legal & state_q[S_ERR];
    busy        = ~reset_input & ~state_q[S_IDLE];
  end

  assign state_dbg = state_q;

endmodule
